basket_controller: RTL and testbench
====================================

Name: basket_controller

Overview:
- Downstream consumer of the sale-terminal state machine's basket-update pulse, product ID and product quantity.
- Keeps a per-product quantity table for 12 products and looks up unit prices from a price ROM.
- Maintains a running item count and total price in cents.
- Provides a read port so display and checkout logic can query any product's quantity.

Parameters:
- NUM_PRODUCTS, 12, number of valid product IDs (0..NUM_PRODUCTS-1).
- MAX_QTY, 99, saturation limit of each per-product quantity.
- PRICE_W, 20, width of TotalPrice in cents.

Ports:
- CLOCK_50 input 1: sole clock, rising edge.
- RESET input 1: asynchronous, active-high reset.
- ENABLE input 1: single-cycle basket-update request.
- REMOVE input 1: sampled with ENABLE; 1 = subtract, 0 = add.
- CLEAR input 1: single-cycle request to empty the basket.
- ProductID_in input 4: product ID for the update.
- ProductQuantity input 4: quantity for the update, 0..15.
- RdProductID input 4: combinational read address.
- RdQuantity output 7: quantity of RdProductID; 0 if the ID is invalid.
- BUSY output 1: high while not in IDLE.
- DONE output 1: one-cycle pulse when an operation has committed.
- CLAMPED output 1: one-cycle pulse together with DONE when the applied quantity was less than requested.
- ERROR output 1: one-cycle pulse when a request is rejected.
- ItemCount output 11: sum of all quantities.
- TotalPrice output PRICE_W: sum of qty x unit price, in cents.
- BasketEmpty output 1: high when ItemCount == 0.

Behaviour:
- Reset: state IDLE; table entries, ItemCount and TotalPrice are 0; BUSY, DONE, CLAMPED and ERROR are 0; BasketEmpty is 1. Reset mid-operation aborts the operation with no partial commit.
- States: IDLE, FETCH, APPLY, CLR.
- IDLE, CLEAR=1: go to CLR with the index at 0. CLEAR has priority over a simultaneous ENABLE, and that ENABLE is dropped.
- IDLE, ENABLE=1: latch ID, quantity and REMOVE.
  - If ID >= NUM_PRODUCTS or quantity == 0, pulse ERROR in the next cycle and stay in IDLE. No other change.
  - Otherwise go to FETCH.
- FETCH: synchronous ROM read of the unit price (1 cycle), plus read of the current table entry cur. Go to APPLY.
- APPLY (add): applied = min(q, MAX_QTY - cur).
- APPLY (remove): applied = min(q, cur).
- APPLY commit, at the clock edge ending APPLY:
  - entry = cur ± applied;
  - ItemCount ± applied;
  - TotalPrice ± applied x price (price 12 bits, product zero-extended to PRICE_W).
  - Go to IDLE.
  - In the first IDLE cycle, DONE=1 and the new values are visible. CLAMPED=1 if applied != q.
  - applied == 0 commits no change but still raises DONE and CLAMPED.
- Latency: ENABLE in cycle N gives DONE in cycle N+3. ERROR appears in cycle N+1.
- CLR: zero one table entry per cycle, index 0..NUM_PRODUCTS-1. On the last index, also zero ItemCount and TotalPrice, then return to IDLE. DONE pulses in the following cycle. BUSY is high for exactly NUM_PRODUCTS cycles.
- While BUSY: ENABLE and CLEAR are ignored. No queueing, no ERROR.
- Overflow: worst case is 99 x 7228 = 715572 < 2^20 and 99 x 12 = 1188 < 2^11, so no wrap is possible. The implementation does not need a saturation path for the totals.
- Subtraction never underflows because applied <= cur.

Decomposition:
- Package basket_pkg holds:
  - NUM_PRODUCTS, MAX_QTY, PRICE_W;
  - the state enum {IDLE, FETCH, APPLY, CLR};
  - the unit price constants in cents, IDs 0..11: 150, 275, 99, 1200, 450, 325, 80, 2500, 600, 199, 350, 1000.
- Sub-module basket_price_rom: registered 4-bit address to 12-bit price, 1-cycle latency, returns 0 for IDs >= NUM_PRODUCTS.

Test Plan:
- Add ID 3 qty 5 from reset -> DONE at N+3; RdQuantity(3)=5, ItemCount=5, TotalPrice=6000, CLAMPED=0, BasketEmpty=0.
- 11 x add ID 7 qty 9 -> qty 99, TotalPrice 247500. A 12th add of qty 9 -> DONE+CLAMPED, no value change.
- With ID 3 = 5, remove qty 8 -> RdQuantity(3)=0, TotalPrice reduced by 6000, CLAMPED=1.
- Add ID 12 qty 2, then add ID 0 qty 0 -> ERROR at N+1 each time, BUSY stays 0, all totals unchanged.
- After several adds, pulse CLEAR together with ENABLE -> BUSY for 12 cycles, every RdQuantity=0, ItemCount=0, TotalPrice=0, DONE once. ENABLE pulses issued during BUSY have no effect.
- Assert RESET during APPLY of add ID 1 qty 4 -> all outputs return to reset values immediately; no commit is observed after RESET deasserts.

Source files
------------

// File: rtl/basket_pkg.sv
// Shared constants, FSM state type and unit-price lookup for the basket controller.
package basket_pkg;

    localparam int NUM_PRODUCTS = 12;
    localparam int MAX_QTY      = 99;
    localparam int PRICE_W      = 20;
    localparam int ID_W         = 4;
    localparam int QTY_IN_W     = 4;
    localparam int QTY_W        = 7;
    localparam int UNIT_PRICE_W = 12;
    localparam int COUNT_W      = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        APPLY = 2'd2,
        CLR   = 2'd3
    } state_t;

    typedef logic [UNIT_PRICE_W-1:0] price_t;

    // Unit prices in cents; unknown IDs cost nothing so a stray read is harmless.
    function automatic price_t unit_price(input logic [ID_W-1:0] id);
        price_t p;
        case (id)
            4'd0:    p = 12'd150;
            4'd1:    p = 12'd275;
            4'd2:    p = 12'd99;
            4'd3:    p = 12'd1200;
            4'd4:    p = 12'd450;
            4'd5:    p = 12'd325;
            4'd6:    p = 12'd80;
            4'd7:    p = 12'd2500;
            4'd8:    p = 12'd600;
            4'd9:    p = 12'd199;
            4'd10:   p = 12'd350;
            4'd11:   p = 12'd1000;
            default: p = 12'd0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/basket_price_rom.sv
// Unit-price ROM with a registered output: price appears one cycle after addr.
module basket_price_rom
    import basket_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [ID_W-1:0] addr,
    output price_t          price
);

    price_t price_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            price_reg <= '0;
        end else begin
            price_reg <= unit_price(addr);
        end
    end

    assign price = price_reg;

endmodule

// File: rtl/basket_controller.sv
// Per-product quantity table with running item count and total price.
// Updates go IDLE -> FETCH -> APPLY; a clear sweeps the table one entry per cycle.
module basket_controller
    import basket_pkg::*;
(
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic                ENABLE,
    input  logic                REMOVE,
    input  logic                CLEAR,
    input  logic [ID_W-1:0]     ProductID_in,
    input  logic [QTY_IN_W-1:0] ProductQuantity,
    input  logic [ID_W-1:0]     RdProductID,
    output logic [QTY_W-1:0]    RdQuantity,
    output logic                BUSY,
    output logic                DONE,
    output logic                CLAMPED,
    output logic                ERROR,
    output logic [COUNT_W-1:0]  ItemCount,
    output logic [PRICE_W-1:0]  TotalPrice,
    output logic                BasketEmpty
);

    state_t state_reg, state_next;

    logic [ID_W-1:0]     id_reg;
    logic [QTY_IN_W-1:0] qty_reg;
    logic                remove_reg;
    logic [ID_W-1:0]     clr_idx_reg;
    logic [QTY_W-1:0]    cur_reg;
    logic [COUNT_W-1:0]  item_count_reg;
    logic [PRICE_W-1:0]  total_price_reg;
    logic                done_reg;
    logic                clamped_reg;
    logic                error_reg;

    logic [NUM_PRODUCTS-1:0][QTY_W-1:0] qty_table;

    price_t              unit_price_q;
    logic                req_take;
    logic                req_invalid;
    logic                req_accept;
    logic                busy;
    logic                commit;
    logic                clr_wr;
    logic                clr_last;
    logic [QTY_W-1:0]    qty_ext;
    logic [QTY_W-1:0]    headroom;
    logic [QTY_W-1:0]    applied;
    logic [QTY_W-1:0]    entry_next;
    logic [PRICE_W-1:0]  price_delta;

    basket_price_rom u_price_rom (
        .clk   (CLOCK_50),
        .rst   (RESET),
        .addr  (id_reg),
        .price (unit_price_q)
    );

    // CLEAR wins over a simultaneous ENABLE, which is then dropped entirely.
    assign req_take    = (state_reg == IDLE) && ENABLE && !CLEAR;
    assign req_invalid = (ProductID_in >= ID_W'(NUM_PRODUCTS)) || (ProductQuantity == '0);
    assign req_accept  = req_take && !req_invalid;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (CLEAR) begin
                    state_next = CLR;
                end else if (req_accept) begin
                    state_next = FETCH;
                end
            end
            FETCH:   state_next = APPLY;
            APPLY:   state_next = IDLE;
            CLR:     state_next = clr_last ? IDLE : CLR;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_reg != IDLE);
        commit   = (state_reg == APPLY);
        clr_wr   = (state_reg == CLR);
        clr_last = (state_reg == CLR) && (clr_idx_reg == ID_W'(NUM_PRODUCTS - 1));
    end

    // applied never exceeds cur on removal, so entry and totals cannot underflow.
    always_comb begin
        qty_ext  = QTY_W'(qty_reg);
        headroom = QTY_W'(MAX_QTY) - cur_reg;
        if (remove_reg) begin
            applied    = (qty_ext < cur_reg) ? qty_ext : cur_reg;
            entry_next = cur_reg - applied;
        end else begin
            applied    = (qty_ext < headroom) ? qty_ext : headroom;
            entry_next = cur_reg + applied;
        end
        price_delta = PRICE_W'(applied) * PRICE_W'(unit_price_q);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PRODUCTS; gi++) begin : g_entry
            logic [QTY_W-1:0] entry_reg;

            always_ff @(posedge CLOCK_50 or posedge RESET) begin
                if (RESET) begin
                    entry_reg <= '0;
                end else if (clr_wr && (clr_idx_reg == ID_W'(gi))) begin
                    entry_reg <= '0;
                end else if (commit && (id_reg == ID_W'(gi))) begin
                    entry_reg <= entry_next;
                end
            end

            assign qty_table[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            id_reg          <= '0;
            qty_reg         <= '0;
            remove_reg      <= 1'b0;
            clr_idx_reg     <= '0;
            cur_reg         <= '0;
            item_count_reg  <= '0;
            total_price_reg <= '0;
            done_reg        <= 1'b0;
            clamped_reg     <= 1'b0;
            error_reg       <= 1'b0;
        end else begin
            if (req_take) begin
                id_reg     <= ProductID_in;
                qty_reg    <= ProductQuantity;
                remove_reg <= REMOVE;
            end
            if (state_reg == FETCH) begin
                cur_reg <= qty_table[id_reg];
            end
            if (state_reg == IDLE) begin
                clr_idx_reg <= '0;
            end else if (clr_wr) begin
                clr_idx_reg <= clr_idx_reg + 1'b1;
            end
            if (commit) begin
                if (remove_reg) begin
                    item_count_reg  <= item_count_reg - COUNT_W'(applied);
                    total_price_reg <= total_price_reg - price_delta;
                end else begin
                    item_count_reg  <= item_count_reg + COUNT_W'(applied);
                    total_price_reg <= total_price_reg + price_delta;
                end
            end else if (clr_last) begin
                item_count_reg  <= '0;
                total_price_reg <= '0;
            end
            done_reg    <= commit || clr_last;
            clamped_reg <= commit && (applied != qty_ext);
            error_reg   <= req_take && req_invalid;
        end
    end

    assign RdQuantity  = (RdProductID < ID_W'(NUM_PRODUCTS)) ? qty_table[RdProductID] : '0;
    assign BUSY        = busy;
    assign DONE        = done_reg;
    assign CLAMPED     = clamped_reg;
    assign ERROR       = error_reg;
    assign ItemCount   = item_count_reg;
    assign TotalPrice  = total_price_reg;
    assign BasketEmpty = (item_count_reg == '0);

endmodule

// File: tb/tb_basket_controller.sv
// Directed bench for basket_controller: latency, saturation, removal, rejects, clear and reset abort.
module tb_basket_controller;

    logic        CLOCK_50 = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic        REMOVE;
    logic        CLEAR;
    logic [3:0]  ProductID_in;
    logic [3:0]  ProductQuantity;
    logic [3:0]  RdProductID;
    logic [6:0]  RdQuantity;
    logic        BUSY;
    logic        DONE;
    logic        CLAMPED;
    logic        ERROR;
    logic [10:0] ItemCount;
    logic [19:0] TotalPrice;
    logic        BasketEmpty;

    int errors = 0;
    int checks = 0;

    basket_controller dut (
        .CLOCK_50        (CLOCK_50),
        .RESET           (RESET),
        .ENABLE          (ENABLE),
        .REMOVE          (REMOVE),
        .CLEAR           (CLEAR),
        .ProductID_in    (ProductID_in),
        .ProductQuantity (ProductQuantity),
        .RdProductID     (RdProductID),
        .RdQuantity      (RdQuantity),
        .BUSY            (BUSY),
        .DONE            (DONE),
        .CLAMPED         (CLAMPED),
        .ERROR           (ERROR),
        .ItemCount       (ItemCount),
        .TotalPrice      (TotalPrice),
        .BasketEmpty     (BasketEmpty)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Drives one request for a single cycle; returns in cycle N+1 with inputs idle.
    task automatic issue(input logic clr, input logic en, input logic rem,
                         input logic [3:0] id, input logic [3:0] qty);
        CLEAR = clr; ENABLE = en; REMOVE = rem; ProductID_in = id; ProductQuantity = qty;
        $display("request clear=%0b enable=%0b remove=%0b id=%0d qty=%0d", clr, en, rem, id, qty);
        tick();
        CLEAR = 1'b0; ENABLE = 1'b0; REMOVE = 1'b0; ProductID_in = '0; ProductQuantity = '0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; ENABLE = 1'b0; REMOVE = 1'b0; CLEAR = 1'b0;
        ProductID_in = '0; ProductQuantity = '0; RdProductID = 4'd3;
        tick(); tick();
        RESET = 1'b0;
        tick();
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", BUSY); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", DONE); end
        checks++; if (ItemCount !== 11'd0) begin errors++; $display("FAIL reset_items: got %0d want 0", ItemCount); end
        checks++; if (TotalPrice !== 20'd0) begin errors++; $display("FAIL reset_total: got %0d want 0", TotalPrice); end
        checks++; if (BasketEmpty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b want 1", BasketEmpty); end
        checks++; if (RdQuantity !== 7'd0) begin errors++; $display("FAIL reset_rdq: got %0d want 0", RdQuantity); end
    endtask

    task automatic test_add();
        issue(1'b0, 1'b1, 1'b0, 4'd3, 4'd5);
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL add_busy_n1: got %0b want 1", BUSY); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL add_done_n1: got %0b want 0", DONE); end
        tick();
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL add_done_n2: got %0b want 0", DONE); end
        tick();
        RdProductID = 4'd3; #1;
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL add_done_n3: got %0b want 1", DONE); end
        checks++; if (CLAMPED !== 1'b0) begin errors++; $display("FAIL add_clamped: got %0b want 0", CLAMPED); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL add_busy_n3: got %0b want 0", BUSY); end
        checks++; if (RdQuantity !== 7'd5) begin errors++; $display("FAIL add_rdq: got %0d want 5", RdQuantity); end
        checks++; if (ItemCount !== 11'd5) begin errors++; $display("FAIL add_items: got %0d want 5", ItemCount); end
        checks++; if (TotalPrice !== 20'd6000) begin errors++; $display("FAIL add_total: got %0d want 6000", TotalPrice); end
        checks++; if (BasketEmpty !== 1'b0) begin errors++; $display("FAIL add_empty: got %0b want 0", BasketEmpty); end
        tick();
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got %0b want 0", DONE); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 11; i++) begin
            issue(1'b0, 1'b1, 1'b0, 4'd7, 4'd9);
            tick(); tick();
            checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL sat_done_%0d: got %0b want 1", i, DONE); end
        end
        RdProductID = 4'd7; #1;
        checks++; if (RdQuantity !== 7'd99) begin errors++; $display("FAIL sat_rdq: got %0d want 99", RdQuantity); end
        checks++; if (TotalPrice !== 20'd253500) begin errors++; $display("FAIL sat_total: got %0d want 253500", TotalPrice); end
        checks++; if (ItemCount !== 11'd104) begin errors++; $display("FAIL sat_items: got %0d want 104", ItemCount); end
        issue(1'b0, 1'b1, 1'b0, 4'd7, 4'd9);
        tick(); tick();
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL sat12_done: got %0b want 1", DONE); end
        checks++; if (CLAMPED !== 1'b1) begin errors++; $display("FAIL sat12_clamped: got %0b want 1", CLAMPED); end
        checks++; if (RdQuantity !== 7'd99) begin errors++; $display("FAIL sat12_rdq: got %0d want 99", RdQuantity); end
        checks++; if (TotalPrice !== 20'd253500) begin errors++; $display("FAIL sat12_total: got %0d want 253500", TotalPrice); end
    endtask

    task automatic test_remove();
        issue(1'b0, 1'b1, 1'b1, 4'd3, 4'd8);
        tick(); tick();
        RdProductID = 4'd3; #1;
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL rem_done: got %0b want 1", DONE); end
        checks++; if (CLAMPED !== 1'b1) begin errors++; $display("FAIL rem_clamped: got %0b want 1", CLAMPED); end
        checks++; if (RdQuantity !== 7'd0) begin errors++; $display("FAIL rem_rdq: got %0d want 0", RdQuantity); end
        checks++; if (TotalPrice !== 20'd247500) begin errors++; $display("FAIL rem_total: got %0d want 247500", TotalPrice); end
        checks++; if (ItemCount !== 11'd99) begin errors++; $display("FAIL rem_items: got %0d want 99", ItemCount); end
    endtask

    task automatic test_error();
        issue(1'b0, 1'b1, 1'b0, 4'd12, 4'd2);
        checks++; if (ERROR !== 1'b1) begin errors++; $display("FAIL err_id_error: got %0b want 1", ERROR); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL err_id_busy: got %0b want 0", BUSY); end
        tick();
        checks++; if (ERROR !== 1'b0) begin errors++; $display("FAIL err_id_pulse: got %0b want 0", ERROR); end
        issue(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        checks++; if (ERROR !== 1'b1) begin errors++; $display("FAIL err_qty_error: got %0b want 1", ERROR); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL err_qty_busy: got %0b want 0", BUSY); end
        tick(); tick();
        RdProductID = 4'd0; #1;
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL err_no_done: got %0b want 0", DONE); end
        checks++; if (RdQuantity !== 7'd0) begin errors++; $display("FAIL err_rdq0: got %0d want 0", RdQuantity); end
        checks++; if (ItemCount !== 11'd99) begin errors++; $display("FAIL err_items: got %0d want 99", ItemCount); end
        checks++; if (TotalPrice !== 20'd247500) begin errors++; $display("FAIL err_total: got %0d want 247500", TotalPrice); end
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 1'b1, 1'b0, 4'd9, 4'd15);
        tick(); tick();
        issue(1'b0, 1'b1, 1'b0, 4'd11, 4'd15);
        tick(); tick();
        issue(1'b0, 1'b1, 1'b1, 4'd9, 4'd3);
        tick(); tick();
        RdProductID = 4'd9; #1;
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL b2b_done: got %0b want 1", DONE); end
        checks++; if (CLAMPED !== 1'b0) begin errors++; $display("FAIL b2b_clamped: got %0b want 0", CLAMPED); end
        checks++; if (RdQuantity !== 7'd12) begin errors++; $display("FAIL b2b_rdq9: got %0d want 12", RdQuantity); end
        checks++; if (ItemCount !== 11'd126) begin errors++; $display("FAIL b2b_items: got %0d want 126", ItemCount); end
        checks++; if (TotalPrice !== 20'd264888) begin errors++; $display("FAIL b2b_total: got %0d want 264888", TotalPrice); end
    endtask

    task automatic test_clear();
        int done_seen;
        done_seen = 0;
        issue(1'b1, 1'b1, 1'b0, 4'd1, 4'd3);
        for (int i = 0; i < 12; i++) begin
            checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL clr_busy_%0d: got %0b want 1", i, BUSY); end
            checks++; if (ERROR !== 1'b0) begin errors++; $display("FAIL clr_error_%0d: got %0b want 0", i, ERROR); end
            if (DONE === 1'b1) done_seen++;
            ENABLE = 1'b1; ProductID_in = 4'd2; ProductQuantity = 4'd1;
            tick();
            ENABLE = 1'b0; ProductID_in = '0; ProductQuantity = '0;
        end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL clr_busy_end: got %0b want 0", BUSY); end
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL clr_done: got %0b want 1", DONE); end
        checks++; if (ItemCount !== 11'd0) begin errors++; $display("FAIL clr_items: got %0d want 0", ItemCount); end
        checks++; if (TotalPrice !== 20'd0) begin errors++; $display("FAIL clr_total: got %0d want 0", TotalPrice); end
        checks++; if (BasketEmpty !== 1'b1) begin errors++; $display("FAIL clr_empty: got %0b want 1", BasketEmpty); end
        for (int id = 0; id < 16; id++) begin
            RdProductID = 4'(id); #1;
            checks++; if (RdQuantity !== 7'd0) begin errors++; $display("FAIL clr_rdq_%0d: got %0d want 0", id, RdQuantity); end
        end
        tick();
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL clr_done_pulse: got %0b want 0", DONE); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL clr_no_queue: got %0b want 0", BUSY); end
        tick(); tick();
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL clr_early_done: got %0d want 0", done_seen); end
        checks++; if (ItemCount !== 11'd0) begin errors++; $display("FAIL clr_items_after: got %0d want 0", ItemCount); end
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 1'b1, 1'b0, 4'd5, 4'd2);
        tick(); tick();
        checks++; if (TotalPrice !== 20'd650) begin errors++; $display("FAIL rst_pre_total: got %0d want 650", TotalPrice); end
        issue(1'b0, 1'b1, 1'b0, 4'd1, 4'd4);
        tick();
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL rst_in_apply: got %0b want 1", BUSY); end
        RESET = 1'b1; #1;
        $display("reset asserted during apply");
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", BUSY); end
        checks++; if (ItemCount !== 11'd0) begin errors++; $display("FAIL rst_items: got %0d want 0", ItemCount); end
        checks++; if (TotalPrice !== 20'd0) begin errors++; $display("FAIL rst_total: got %0d want 0", TotalPrice); end
        checks++; if (BasketEmpty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %0b want 1", BasketEmpty); end
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL rst_done_%0d: got %0b want 0", i, DONE); end
        end
        RdProductID = 4'd1; #1;
        checks++; if (RdQuantity !== 7'd0) begin errors++; $display("FAIL rst_rdq1: got %0d want 0", RdQuantity); end
        RdProductID = 4'd5; #1;
        checks++; if (RdQuantity !== 7'd0) begin errors++; $display("FAIL rst_rdq5: got %0d want 0", RdQuantity); end
        checks++; if (ItemCount !== 11'd0) begin errors++; $display("FAIL rst_items_after: got %0d want 0", ItemCount); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_saturate();
        test_remove();
        test_error();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
